// File: rtl/usb_tx_pkg.sv
// Shared USB transmit definitions: packet kinds, CRC selector codes, PID values
// and the FSM state encoding used by the packet serializer.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    KIND_SPECIAL   = 2'b00,
    KIND_TOKEN     = 2'b01,
    KIND_HANDSHAKE = 2'b10,
    KIND_DATA      = 2'b11
  } pkt_kind_e;

  localparam logic [1:0] CRC_SEL_NONE = 2'b00;
  localparam logic [1:0] CRC_SEL_5    = 2'b01;
  localparam logic [1:0] CRC_SEL_16   = 2'b10;

  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  localparam int SYNC_BITS_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SYNC      = 3'd1,
    ST_PID       = 3'd2,
    ST_BODY      = 3'd3,
    ST_WAIT_DONE = 3'd4
  } tx_state_e;

  // Tokens carry CRC5, data packets CRC16, everything else is unprotected.
  function automatic logic [1:0] kind_to_crc(input logic [1:0] kind);
    case (pkt_kind_e'(kind))
      KIND_TOKEN: return CRC_SEL_5;
      KIND_DATA:  return CRC_SEL_16;
      default:    return CRC_SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/usb_bit_counter.sv
// Up-counter with synchronous clear (priority) and count enable.
module usb_bit_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/usb_pkt_serializer.sv
// USB transmit packet serializer: SYNC, PID and body shifted out LSB first over a
// stallable bit stream, with CRC framing hints for the downstream CRC/stuff stage.
module usb_pkt_serializer
  import usb_tx_pkg::*;
#(
  parameter int MAX_PAYLOAD_BYTES = 8,
  parameter int SYNC_BITS         = SYNC_BITS_DEFAULT,
  localparam int MAXBITS          = 8 * (MAX_PAYLOAD_BYTES + 1),
  localparam int LENW             = $clog2(MAXBITS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pkt_valid,
  output logic               pkt_ready,
  input  logic [1:0]         pkt_kind,
  input  logic [LENW-1:0]    pkt_bits,
  input  logic [MAXBITS-1:0] pkt_data,
  input  logic               abort,
  input  logic               tx_done,
  output logic               bit_out,
  output logic               bit_valid,
  input  logic               bit_ready,
  output logic               bit_last,
  output logic               crc_init,
  output logic [1:0]         crc_sel,
  output logic               crc_en,
  output logic               len_err
);

  localparam int CMAX = (SYNC_BITS > MAXBITS) ? SYNC_BITS : MAXBITS;
  localparam int CNTW = $clog2(CMAX + 1);
  localparam int IW   = $clog2(MAXBITS);
  localparam int AW   = ((CNTW > LENW) ? CNTW : LENW) + 1;

  tx_state_e          state_reg, state_next;
  logic [MAXBITS-1:0] data_reg;
  logic [LENW-1:0]    len_reg, len_next;
  logic [1:0]         crc_sel_reg;
  logic [CNTW-1:0]    cnt;
  logic               accept, fire, range_err, cnt_clr;
  logic [AW-1:0]      body_idx, len_ext;
  logic [IW-1:0]      pid_idx, data_idx;

  usb_bit_counter #(.W(CNTW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (fire),
    .cnt   (cnt)
  );

  assign range_err = (pkt_bits < LENW'(8)) || (pkt_bits > LENW'(MAXBITS));
  assign accept    = (state_reg == ST_IDLE) && pkt_valid && !abort;
  assign fire      = bit_valid && bit_ready;
  assign cnt_clr   = (state_next != state_reg);
  // Body bits follow the 8 PID bits, so the body index is offset by 8.
  assign body_idx  = AW'(cnt) + AW'(8);
  assign len_ext   = AW'(len_reg);
  assign pid_idx   = IW'(cnt);
  assign data_idx  = IW'(body_idx);
  assign crc_sel   = crc_sel_reg;

  always_comb begin
    len_next = pkt_bits;
    if (pkt_bits < LENW'(8)) begin
      len_next = LENW'(8);
    end else if (pkt_bits > LENW'(MAXBITS)) begin
      len_next = LENW'(MAXBITS);
    end
  end

  always_comb begin
    state_next = state_reg;
    pkt_ready  = 1'b0;
    bit_valid  = 1'b0;
    bit_out    = 1'b0;
    bit_last   = 1'b0;
    crc_en     = 1'b0;
    crc_init   = 1'b0;
    len_err    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        pkt_ready = 1'b1;
        if (accept) begin
          crc_init   = 1'b1;
          len_err    = range_err;
          state_next = ST_SYNC;
        end
      end
      ST_SYNC: begin
        bit_valid = 1'b1;
        bit_out   = (cnt == CNTW'(SYNC_BITS - 1));
        if (bit_ready && bit_out) begin
          state_next = ST_PID;
        end
      end
      ST_PID: begin
        bit_valid = 1'b1;
        bit_out   = data_reg[pid_idx];
        bit_last  = (len_reg == LENW'(8)) && (cnt == CNTW'(7));
        if (bit_ready && (cnt == CNTW'(7))) begin
          state_next = bit_last ? ST_WAIT_DONE : ST_BODY;
        end
      end
      ST_BODY: begin
        bit_valid = 1'b1;
        bit_out   = data_reg[data_idx];
        bit_last  = (body_idx == len_ext - AW'(1));
        crc_en    = (crc_sel_reg != CRC_SEL_NONE);
        if (bit_ready && bit_last) begin
          state_next = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_done) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (abort && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      data_reg    <= '0;
      len_reg     <= LENW'(8);
      crc_sel_reg <= CRC_SEL_NONE;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        data_reg    <= pkt_data;
        len_reg     <= len_next;
        crc_sel_reg <= kind_to_crc(pkt_kind);
      end else if (state_next == ST_IDLE) begin
        crc_sel_reg <= CRC_SEL_NONE;
      end
    end
  end

endmodule

// File: tb/tb_usb_pkt_serializer.sv
// Scoreboard bench for usb_pkt_serializer: expected bit stream queued at packet
// launch, compared bit by bit (including stalled cycles) as the DUT emits it.
module tb_usb_pkt_serializer;

  localparam int SB   = 8;
  localparam int MAXB = 72;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pkt_valid = 1'b0;
  logic        pkt_ready;
  logic [1:0]  pkt_kind = 2'b00;
  logic [6:0]  pkt_bits = 7'd0;
  logic [71:0] pkt_data = '0;
  logic        abort = 1'b0;
  logic        tx_done = 1'b0;
  logic        bit_out, bit_valid, bit_last;
  logic        bit_ready = 1'b1;
  logic        crc_init, crc_en, len_err;
  logic [1:0]  crc_sel;

  typedef struct packed {
    logic b;
    logic last;
    logic ce;
  } exp_t;

  exp_t exp_q[$];
  logic [1:0] exp_sel = 2'b00;
  int n_compared = 0;
  int n_mismatched = 0;
  int n_fired = 0;
  int n_init = 0;
  int n_acc = 0;
  int cyc = 0;
  int t_acc = 0;
  int last_cyc = 0;
  bit rnd_ready = 1'b0;

  usb_pkt_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_kind  (pkt_kind),
    .pkt_bits  (pkt_bits),
    .pkt_data  (pkt_data),
    .abort     (abort),
    .tx_done   (tx_done),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .bit_last  (bit_last),
    .crc_init  (crc_init),
    .crc_sel   (crc_sel),
    .crc_en    (crc_en),
    .len_err   (len_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output bits are compared against the queue head on every valid cycle, so a
  // stall that disturbs bit_out/bit_last/crc_en shows up as a mismatch.
  always @(negedge clk) begin
    if (rst_n && bit_valid) begin
      if (exp_q.size() == 0) begin
        check("extra_bit", 32'd1, 32'd0);
      end else begin
        check($sformatf("bit%0d", n_fired), {27'd0, bit_out, bit_last, crc_en, crc_sel},
              {27'd0, exp_q[0].b, exp_q[0].last, exp_q[0].ce, exp_sel});
        if (bit_ready) begin
          if (bit_last) last_cyc = cyc;
          void'(exp_q.pop_front());
          n_fired++;
        end
      end
    end
    if (rst_n && crc_init) n_init++;
  end

  function automatic logic [1:0] model_sel(input logic [1:0] kind);
    if (kind == 2'b01) return 2'b01;
    if (kind == 2'b11) return 2'b10;
    return 2'b00;
  endfunction

  task automatic send_pkt(input logic [1:0] kind, input int bits, input logic [71:0] data,
                          input bit rnd);
    int len;
    logic [1:0] sel;
    len = (bits < 8) ? 8 : ((bits > MAXB) ? MAXB : bits);
    sel = model_sel(kind);
    for (int i = 0; i < SB; i++) exp_q.push_back('{b: (i == SB - 1), last: 1'b0, ce: 1'b0});
    for (int i = 0; i < len; i++)
      exp_q.push_back('{b: data[i], last: (i == len - 1), ce: (i >= 8) && (sel != 2'b00)});
    @(posedge clk);
    #1;
    exp_sel   = sel;
    n_fired   = 0;
    rnd_ready = rnd;
    bit_ready = 1'b1;
    pkt_valid = 1'b1;
    pkt_kind  = kind;
    pkt_bits  = 7'(bits);
    pkt_data  = data;
    @(negedge clk);
    t_acc = cyc;
    n_acc++;
    check("accept", {29'd0, pkt_ready, crc_init, len_err},
          {29'd0, 1'b1, 1'b1, (bits < 8) || (bits > MAXB)});
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
    pkt_data  = '0;
  endtask

  task automatic wait_fired(input int target, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      if (n_fired >= target) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
        if (rnd_ready) bit_ready = 1'($urandom_range(0, 1));
      end
    end
    if (!done) check("timeout", 32'(n_fired), 32'(target));
    bit_ready = 1'b1;
    rnd_ready = 1'b0;
  endtask

  task automatic finish_pkt(input int len, input bit timed);
    wait_fired(SB + len, 40 * (SB + len) + 50);
    if (timed) check("last_cycle", 32'(last_cyc - t_acc), 32'(SB + len));
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("wait_done", {30'd0, pkt_ready, bit_valid}, 32'd0);
    @(posedge clk);
    #1 tx_done = 1'b1;
    @(negedge clk);
    check("tx_done_cycle", {31'd0, pkt_ready}, 32'd0);
    @(posedge clk);
    #1 tx_done = 1'b0;
    @(negedge clk);
    check("ready_after_done", {29'd0, pkt_ready, crc_sel}, {29'd0, 1'b1, 2'b00});
  endtask

  initial begin
    logic [71:0] d;

    #2;
    check("reset_outputs",
          {23'd0, pkt_ready, bit_valid, bit_out, bit_last, crc_init, crc_sel, crc_en, len_err},
          {23'd0, 9'b1_0000_0000});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ACK handshake, no stalls.
    send_pkt(2'b10, 8, 72'hD2, 1'b0);
    finish_pkt(8, 1'b1);

    // IN token with random stalls.
    d = {53'd0, 11'h0A5, 8'h69};
    send_pkt(2'b01, 19, d, 1'b1);
    finish_pkt(19, 1'b0);

    // DATA0 with eight bytes 01..08.
    d = 72'hC3;
    for (int k = 1; k <= 8; k++) d[8*k +: 8] = 8'(k);
    send_pkt(2'b11, 72, d, 1'b0);
    finish_pkt(72, 1'b1);

    // Length clamps: short body bits must not be transmitted.
    send_pkt(2'b10, 3, 72'hFFFF_5A, 1'b0);
    finish_pkt(8, 1'b1);
    d = '0;
    for (int k = 0; k < 9; k++) d[8*k +: 8] = 8'(8'hA7 ^ (k * 37));
    send_pkt(2'b11, 100, d, 1'b0);
    finish_pkt(72, 1'b1);

    // Abort in IDLE beats a simultaneous pkt_valid.
    @(posedge clk);
    #1;
    pkt_valid = 1'b1;
    abort     = 1'b1;
    pkt_bits  = 7'd3;
    @(negedge clk);
    check("idle_abort_accept", {29'd0, pkt_ready, crc_init, len_err}, {29'd0, 3'b100});
    @(posedge clk);
    #1;
    pkt_valid = 1'b0;
    abort     = 1'b0;
    @(negedge clk);
    check("idle_abort_stay", {30'd0, pkt_ready, bit_valid}, {30'd0, 2'b10});

    // Abort while body bit 5 of a data packet is on the line.
    d = 72'hC3;
    for (int k = 1; k <= 8; k++) d[8*k +: 8] = 8'(8'h10 + k);
    send_pkt(2'b11, 72, d, 1'b0);
    wait_fired(SB + 8 + 5, 200);
    abort = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 abort = 1'b0;
    exp_q.delete();
    exp_sel = 2'b00;
    @(negedge clk);
    check("after_abort", {28'd0, pkt_ready, bit_valid, bit_last, crc_sel == 2'b00},
          {28'd0, 4'b1001});
    send_pkt(2'b10, 8, 72'hD2, 1'b0);
    finish_pkt(8, 1'b1);

    // Asynchronous reset in the middle of a body.
    send_pkt(2'b11, 72, d, 1'b0);
    wait_fired(SB + 8 + 2, 200);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_body",
          {23'd0, pkt_ready, bit_valid, bit_out, bit_last, crc_init, crc_sel, crc_en, len_err},
          {23'd0, 9'b1_0000_0000});
    exp_q.delete();
    exp_sel = 2'b00;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_pkt(2'b01, 19, {53'd0, 11'h3C1, 8'hE1}, 1'b0);
    finish_pkt(19, 1'b1);

    check("crc_init_count", 32'(n_init), 32'(n_acc));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
